// File: rtl/nibble_sequencer.sv
// nibble_sequencer: fetch/decode/execute control for the Full Nibble Processor.
// Optional overflow trap enabled by defining OVF_TRAP_EN (adds the trap port).
module nibble_sequencer #(
   parameter int ADDR_W   = 4,
   parameter int INSTR_W  = 8,
   parameter int START_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic              ovf,
   output logic              acc_we,
   output logic [1:0]        sel_mux1,
   output logic              sel_mux2,
   output logic              sel_mux3,
   output logic [ADDR_W-1:0] operand_addr,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic              busy,
   output logic              ended,
   output logic              ovf_flag
`ifdef OVF_TRAP_EN
   ,
   output logic              trap
`endif
);

   localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(START_PC);
   localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_INC  = 3'b010;
   localparam logic [2:0] OP_LDQ  = 3'b011;
   localparam logic [2:0] OP_DUMP = 3'b100;
   localparam logic [2:0] OP_END  = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_DUMP_WAIT,
      S_HALT
   } state_t;

   state_t               state;
   logic [ADDR_W-1:0]    pc;
   logic [INSTR_W-1:0]   ir;
   logic [2:0]           op;
   logic                 writes_acc;
   logic                 tracks_ovf;
   logic                 rsv_unused;

   assign op           = ir[INSTR_W-1 -: 3];
   assign rsv_unused   = ir[INSTR_W-4];
   assign imem_addr    = pc;
   assign operand_addr = ir[ADDR_W-1:0];
   assign writes_acc   = ~op[2];
   assign tracks_ovf   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);

   // Mux select pattern {sel_mux1, sel_mux2, sel_mux3} for an opcode
   function automatic logic [3:0] sel_of(input logic [2:0] o);
      logic [3:0] s;
      s = 4'b0000;
      case (o)
         OP_SUB:  s = 4'b0100;
         OP_INC:  s = 4'b1000;
         OP_LDQ:  s = 4'b0010;
         OP_DUMP: s = 4'b0001;
         default: s = 4'b0000;
      endcase
      return s;
   endfunction

   // Sequencer FSM with all control outputs registered alongside the state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc         <= PC_INIT;
         ir         <= '0;
         ovf_flag   <= 1'b0;
         imem_req   <= 1'b0;
         acc_we     <= 1'b0;
         sel_mux1   <= 2'b00;
         sel_mux2   <= 1'b0;
         sel_mux3   <= 1'b0;
         dump_valid <= 1'b0;
         busy       <= 1'b0;
         ended      <= 1'b0;
`ifdef OVF_TRAP_EN
         trap       <= 1'b0;
`endif
      end else begin
         acc_we <= 1'b0;
         unique case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  pc       <= PC_INIT;
                  ovf_flag <= 1'b0;
                  imem_req <= 1'b1;
                  busy     <= 1'b1;
                  ended    <= 1'b0;
`ifdef OVF_TRAP_EN
                  trap     <= 1'b0;
`endif
                  state    <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (imem_valid) begin
                  ir       <= imem_data;
                  imem_req <= 1'b0;
                  {sel_mux1, sel_mux2, sel_mux3} <=
                     sel_of(imem_data[INSTR_W-1 -: 3]);
                  state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (op == OP_END) begin
                  {sel_mux1, sel_mux2, sel_mux3} <= 4'b0000;
                  busy  <= 1'b0;
                  ended <= 1'b1;
                  state <= S_HALT;
               end else if (op == OP_DUMP) begin
                  dump_valid <= 1'b1;
                  state      <= S_DUMP_WAIT;
               end else begin
                  acc_we <= writes_acc;
                  state  <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (tracks_ovf) begin
                  ovf_flag <= ovf_flag | ovf;
               end
               {sel_mux1, sel_mux2, sel_mux3} <= 4'b0000;
`ifdef OVF_TRAP_EN
               if (tracks_ovf && ovf) begin
                  busy  <= 1'b0;
                  ended <= 1'b1;
                  trap  <= 1'b1;
                  state <= S_HALT;
               end else begin
`else
               begin
`endif
                  pc       <= pc + PC_ONE;
                  imem_req <= 1'b1;
                  state    <= S_FETCH;
               end
            end
            S_DUMP_WAIT: begin
               if (dump_ready) begin
                  dump_valid <= 1'b0;
                  sel_mux3   <= 1'b0;
                  pc         <= pc + PC_ONE;
                  imem_req   <= 1'b1;
                  state      <= S_FETCH;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_sequencer.sv
// tb_nibble_sequencer: directed checks of the nibble_sequencer control flow.
// Table of single-instruction vectors plus hand-timed multi-cycle sequences.
module tb_nibble_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       imem_req;
   logic [3:0] imem_addr;
   logic       imem_valid;
   logic [7:0] imem_data;
   logic       ovf_in = 1'b0;
   logic       acc_we;
   logic [1:0] sel_mux1;
   logic       sel_mux2;
   logic       sel_mux3;
   logic [3:0] operand_addr;
   logic       dump_valid;
   logic       dump_ready = 1'b1;
   logic       busy;
   logic       ended;
   logic       ovf_flag;
`ifdef OVF_TRAP_EN
   logic       trap;
`endif

   logic [7:0] mem [16];
   int         fetch_delay = 0;
   int         req_age = 0;
   int         passes = 0;
   int         total = 0;

   always #5 clk = ~clk;

   assign imem_valid = imem_req && (req_age >= fetch_delay);
   assign imem_data  = mem[imem_addr];

   always @(posedge clk) begin
      if (!imem_req || imem_valid) req_age <= 0;
      else req_age <= req_age + 1;
   end

   nibble_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_valid   (imem_valid),
      .imem_data    (imem_data),
      .ovf          (ovf_in),
      .acc_we       (acc_we),
      .sel_mux1     (sel_mux1),
      .sel_mux2     (sel_mux2),
      .sel_mux3     (sel_mux3),
      .operand_addr (operand_addr),
      .dump_valid   (dump_valid),
      .dump_ready   (dump_ready),
      .busy         (busy),
      .ended        (ended),
      .ovf_flag     (ovf_flag)
`ifdef OVF_TRAP_EN
      ,
      .trap         (trap)
`endif
   );

   typedef struct {
      logic [7:0] instr;
      logic [1:0] s1;
      logic       s2;
      logic       s3;
      logic       we;
      logic       ovf;
      logic       flag;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_accept();
      int i;
      for (i = 0; i < 30; i++) begin
         if (imem_req && imem_valid) break;
         step();
      end
      chk("fetch_timeout", {31'd0, imem_req && imem_valid}, 32'd1);
      step();
   endtask

   task automatic wait_ended();
      for (int i = 0; i < 60; i++) begin
         if (ended) break;
         step();
      end
      chk("ended_timeout", {31'd0, ended}, 32'd1);
   endtask

   logic [15:0] m_a;
   logic [15:0] m_b;
   logic [15:0] m_c;
   int          cnt_a;
   int          cnt_b;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'hE0;

      // Reset state
      step();
      step();
      chk("rst_req", {31'd0, imem_req}, 0);
      chk("rst_addr", {28'd0, imem_addr}, 0);
      chk("rst_outs", {24'd0, acc_we, sel_mux1, sel_mux2, sel_mux3,
                       dump_valid, busy, ended}, 0);
      chk("rst_flag", {31'd0, ovf_flag}, 0);
      chk("rst_opnd", {28'd0, operand_addr}, 0);
      rst_n = 1'b1;
      step();

      // Program ADD 3, INC, END with zero-latency fetch
      mem[0] = 8'h03;
      mem[1] = 8'h40;
      mem[2] = 8'hE0;
      m_a = '0;
      m_b = '0;
      pulse_start();
      for (int n = 1; n <= 10; n++) begin
         if (acc_we) m_a[n] = 1'b1;
         if (ended) m_b[n] = 1'b1;
         if (n == 3) chk("prog_sel1_add", {30'd0, sel_mux1}, 0);
         if (n == 6) chk("prog_sel1_inc", {30'd0, sel_mux1}, 2);
         if (n == 9) chk("prog_halt_pc", {28'd0, imem_addr}, 2);
         if (n < 10) step();
      end
      chk("prog_we_cycles", {16'd0, m_a}, 32'h48);
      chk("prog_ended_cycles", {16'd0, m_b}, 32'h600);

      // Table of single-instruction vectors
      tbl[0] = '{8'h03, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{8'h65, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{8'hA9, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{8'h40, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{8'h84, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{8'hC7, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{8'h22, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[7] = '{8'h0F, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) mem[i] = tbl[i].instr;
      mem[8] = 8'hE0;
      dump_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         wait_accept();
         chk($sformatf("v%0d_sel", i),
             {28'd0, sel_mux1, sel_mux2, sel_mux3},
             {28'd0, tbl[i].s1, tbl[i].s2, tbl[i].s3});
         chk($sformatf("v%0d_pc", i), {28'd0, imem_addr}, i);
         chk($sformatf("v%0d_opnd", i), {28'd0, operand_addr},
             {28'd0, tbl[i].instr[3:0]});
         ovf_in = tbl[i].ovf;
         step();
         chk($sformatf("v%0d_we", i), {31'd0, acc_we}, {31'd0, tbl[i].we});
         chk($sformatf("v%0d_dv", i), {31'd0, dump_valid},
             {31'd0, tbl[i].s3});
         step();
         ovf_in = 1'b0;
         chk($sformatf("v%0d_flag", i), {31'd0, ovf_flag},
             {31'd0, tbl[i].flag});
         chk($sformatf("v%0d_we_off", i), {31'd0, acc_we}, 0);
      end
      wait_ended();
      chk("tbl_flag_sticky", {31'd0, ovf_flag}, 1);

      // Fetch stall of four cycles
      mem[0] = 8'h01;
      mem[1] = 8'hE0;
      fetch_delay = 4;
      m_a = '0;
      m_b = '0;
      cnt_a = 0;
      pulse_start();
      chk("restart_clr_flag", {31'd0, ovf_flag}, 0);
      for (int n = 1; n <= 7; n++) begin
         if (imem_req) m_a[n] = 1'b1;
         if (imem_req && imem_addr != 4'd0) cnt_a++;
         if (acc_we) m_b[n] = 1'b1;
         if (n < 7) step();
      end
      chk("stall_req_cycles", {16'd0, m_a}, 32'h3E);
      chk("stall_addr_moved", cnt_a, 0);
      chk("stall_we_cycles", {16'd0, m_b}, 32'h80);
      wait_ended();
      fetch_delay = 0;
      step();

      // DUMP held off by dump_ready for three cycles
      mem[0] = 8'h84;
      mem[1] = 8'hE0;
      dump_ready = 1'b0;
      m_a = '0;
      m_b = '0;
      m_c = '0;
      pulse_start();
      for (int n = 1; n <= 8; n++) begin
         if (n == 6) dump_ready = 1'b1;
         if (dump_valid) m_a[n] = 1'b1;
         if (sel_mux3) m_b[n] = 1'b1;
         if (imem_addr == 4'd1) m_c[n] = 1'b1;
         if (n < 8) step();
      end
      chk("dump_valid_cycles", {16'd0, m_a}, 32'h78);
      chk("dump_sel3_cycles", {16'd0, m_b}, 32'h7C);
      chk("dump_pc_after", {16'd0, m_c}, 32'h180);
      wait_ended();
      step();

      // Sixteen NOPs wrap the PC without halting
      for (int i = 0; i < 16; i++) mem[i] = 8'hA0;
      cnt_a = 0;
      cnt_b = 0;
      pulse_start();
      for (int n = 1; n <= 52; n++) begin
         if (n == 20) start = 1'b1;
         if (n == 21) start = 1'b0;
         if (acc_we) cnt_a++;
         if (ended) cnt_b++;
         if (n == 46) chk("wrap_pc15", {28'd0, imem_addr}, 15);
         if (n == 49) chk("wrap_pc0", {28'd0, imem_addr}, 0);
         if (n == 49) chk("wrap_req", {31'd0, imem_req}, 1);
         if (n < 52) step();
      end
      chk("wrap_no_we", cnt_a, 0);
      chk("wrap_no_end", cnt_b, 0);
      chk("wrap_busy", {31'd0, busy}, 1);

      // Reset while waiting on a dump
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      mem[0] = 8'h20;
      mem[1] = 8'h84;
      mem[2] = 8'hE0;
      dump_ready = 1'b0;
      pulse_start();
      for (int n = 1; n <= 7; n++) begin
         if (n == 3) ovf_in = 1'b1;
         if (n == 4) ovf_in = 1'b0;
         if (n == 6) begin
            chk("pre_rst_dv", {31'd0, dump_valid}, 1);
            chk("pre_rst_flag", {31'd0, ovf_flag}, 1);
            rst_n = 1'b0;
         end
         if (n < 7) step();
      end
      chk("mid_rst_dv", {31'd0, dump_valid}, 0);
      chk("mid_rst_pc", {28'd0, imem_addr}, 0);
      chk("mid_rst_flag", {31'd0, ovf_flag}, 0);
      chk("mid_rst_idle", {29'd0, busy, imem_req, sel_mux3}, 0);
      rst_n = 1'b1;
      dump_ready = 1'b1;
      step();
      chk("idle_stays", {30'd0, busy, imem_req}, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
